// File: rtl/sparc_pkg.sv
// rtl/sparc_pkg.sv - shared SPARC op3 codes and multiply/divide FSM state type
package sparc_pkg;

    localparam logic [5:0] OP_UMUL   = 6'h0A;
    localparam logic [5:0] OP_SMUL   = 6'h0B;
    localparam logic [5:0] OP_UDIV   = 6'h0E;
    localparam logic [5:0] OP_SDIV   = 6'h0F;
    localparam logic [5:0] OP_UMULCC = 6'h1A;
    localparam logic [5:0] OP_SMULCC = 6'h1B;
    localparam logic [5:0] OP_UDIVCC = 6'h1E;
    localparam logic [5:0] OP_SDIVCC = 6'h1F;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } muldiv_state_e;

    // True for the eight multiply/divide op3 codes this unit executes.
    function automatic logic is_muldiv_op(input logic [5:0] op);
        return (op == OP_UMUL)   || (op == OP_SMUL)   ||
               (op == OP_UDIV)   || (op == OP_SDIV)   ||
               (op == OP_UMULCC) || (op == OP_SMULCC) ||
               (op == OP_UDIVCC) || (op == OP_SDIVCC);
    endfunction

endpackage

// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - iterative SPARC multiply/divide execute unit
module ex_muldiv
    import sparc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  op3,
    input  logic [31:0] valA,
    input  logic [31:0] valB,
    input  logic [31:0] Y_in,
    output logic        ex_ready,
    output logic        result_valid,
    output logic [31:0] result,
    output logic [31:0] Y_out,
    output logic        icc_n,
    output logic        icc_z,
    output logic        icc_v,
    output logic        icc_c,
    output logic        icc_we,
    output logic        div_zero
);

    muldiv_state_e state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;       // multiply: {partial product, multiplier}; divide: {remainder, quotient}
    logic [31:0] opr_q, opr_d;       // multiplicand or divisor magnitude
    logic [31:0] y_q, y_d;
    logic        is_div_q, is_div_d;
    logic        is_sgn_q, is_sgn_d;
    logic        is_cc_q, is_cc_d;
    logic        neg_q, neg_d;       // final result must be negated
    logic        ovf_q, ovf_d;       // quotient known to overflow before iterating
    logic        dz_q, dz_d;
    logic [31:0] result_q, result_d;
    logic [31:0] y_out_q, y_out_d;
    logic        icc_n_q, icc_n_d;
    logic        icc_z_q, icc_z_d;
    logic        icc_v_q, icc_v_d;
    logic        icc_c_q, icc_c_d;
    logic        icc_we_q, icc_we_d;
    logic        div_zero_q, div_zero_d;
    logic        valid_q, valid_d;

    // Operand preparation: magnitudes for signed ops, early-exit detection for divides.
    logic        op_div, op_sgn, accept, skip_calc;
    logic [31:0] a_mag, b_mag;
    logic [63:0] dvd, dvd_mag;
    logic        setup_neg, setup_ovf, setup_dz;

    always_comb begin
        op_div    = op3[2];
        op_sgn    = op3[0];
        a_mag     = (op_sgn && valA[31]) ? -valA : valA;
        b_mag     = (op_sgn && valB[31]) ? -valB : valB;
        dvd       = {Y_in, valA};
        dvd_mag   = (op_sgn && Y_in[31]) ? -dvd : dvd;
        setup_dz  = (valB == 32'd0);
        if (op_div) begin
            setup_neg = op_sgn && (Y_in[31] ^ valB[31]);
            setup_ovf = op_sgn ? (dvd_mag[63:32] >= b_mag) : (Y_in >= valB);
        end else begin
            setup_neg = op_sgn && (valA[31] ^ valB[31]);
            setup_ovf = 1'b0;
        end
        skip_calc = op_div && (setup_dz || (!op_sgn && (Y_in >= valB)));
        accept    = start && ((state_q == ST_IDLE) || (state_q == ST_DONE)) && is_muldiv_op(op3);
    end

    // One radix-2 step: shift-add for multiply, restoring subtract for divide.
    logic [32:0] mul_sum, div_diff;
    logic [63:0] acc_step;

    always_comb begin
        mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opr_q} : 33'd0);
        div_diff = acc_q[63:31] - {1'b0, opr_q};
        if (!is_div_q) begin
            acc_step = {mul_sum, acc_q[31:1]};
        end else if (!div_diff[32]) begin
            acc_step = {div_diff[31:0], acc_q[30:0], 1'b1};
        end else begin
            acc_step = {acc_q[62:0], 1'b0};
        end
    end

    // Final sign fix-up, saturation and condition-code formation.
    logic [63:0] prod;
    logic [31:0] quo, fix_res, fix_y;
    logic        fix_v;

    always_comb begin
        prod    = neg_q ? -acc_q : acc_q;
        quo     = acc_q[31:0];
        fix_res = prod[31:0];
        fix_y   = prod[63:32];
        fix_v   = 1'b0;
        if (is_div_q) begin
            fix_y = y_q;
            if (dz_q) begin
                fix_res = 32'hFFFF_FFFF;
            end else if (!is_sgn_q) begin
                fix_res = ovf_q ? 32'hFFFF_FFFF : quo;
                fix_v   = ovf_q;
            end else if (neg_q) begin
                if (ovf_q || (quo > 32'h8000_0000)) begin
                    fix_res = 32'h8000_0000;
                    fix_v   = 1'b1;
                end else begin
                    fix_res = -quo;
                end
            end else begin
                if (ovf_q || quo[31]) begin
                    fix_res = 32'h7FFF_FFFF;
                    fix_v   = 1'b1;
                end else begin
                    fix_res = quo;
                end
            end
        end
    end

    // Next-state and datapath register updates.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opr_d      = opr_q;
        y_d        = y_q;
        is_div_d   = is_div_q;
        is_sgn_d   = is_sgn_q;
        is_cc_d    = is_cc_q;
        neg_d      = neg_q;
        ovf_d      = ovf_q;
        dz_d       = dz_q;
        result_d   = result_q;
        y_out_d    = y_out_q;
        icc_n_d    = icc_n_q;
        icc_z_d    = icc_z_q;
        icc_v_d    = icc_v_q;
        icc_c_d    = icc_c_q;
        icc_we_d   = 1'b0;
        div_zero_d = 1'b0;
        valid_d    = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    is_div_d = op_div;
                    is_sgn_d = op_sgn;
                    is_cc_d  = op3[4];
                    neg_d    = setup_neg;
                    ovf_d    = setup_ovf;
                    dz_d     = op_div && setup_dz;
                    y_d      = Y_in;
                    opr_d    = b_mag;
                    acc_d    = op_div ? dvd_mag : {32'd0, a_mag};
                    cnt_d    = 5'd0;
                    state_d  = skip_calc ? ST_FIX : ST_CALC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                acc_d = acc_step;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                result_d   = fix_res;
                y_out_d    = fix_y;
                valid_d    = 1'b1;
                div_zero_d = dz_q;
                if (is_cc_q) begin
                    icc_we_d = 1'b1;
                    icc_n_d  = fix_res[31];
                    icc_z_d  = (fix_res == 32'd0);
                    icc_v_d  = fix_v;
                    icc_c_d  = 1'b0;
                end
                state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register with synchronous reset taking priority over start.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 5'd0;
            acc_q      <= 64'd0;
            opr_q      <= 32'd0;
            y_q        <= 32'd0;
            is_div_q   <= 1'b0;
            is_sgn_q   <= 1'b0;
            is_cc_q    <= 1'b0;
            neg_q      <= 1'b0;
            ovf_q      <= 1'b0;
            dz_q       <= 1'b0;
            result_q   <= 32'd0;
            y_out_q    <= 32'd0;
            icc_n_q    <= 1'b0;
            icc_z_q    <= 1'b0;
            icc_v_q    <= 1'b0;
            icc_c_q    <= 1'b0;
            icc_we_q   <= 1'b0;
            div_zero_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opr_q      <= opr_d;
            y_q        <= y_d;
            is_div_q   <= is_div_d;
            is_sgn_q   <= is_sgn_d;
            is_cc_q    <= is_cc_d;
            neg_q      <= neg_d;
            ovf_q      <= ovf_d;
            dz_q       <= dz_d;
            result_q   <= result_d;
            y_out_q    <= y_out_d;
            icc_n_q    <= icc_n_d;
            icc_z_q    <= icc_z_d;
            icc_v_q    <= icc_v_d;
            icc_c_q    <= icc_c_d;
            icc_we_q   <= icc_we_d;
            div_zero_q <= div_zero_d;
            valid_q    <= valid_d;
        end
    end

    assign ex_ready     = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign result_valid = valid_q;
    assign result       = result_q;
    assign Y_out        = y_out_q;
    assign icc_n        = icc_n_q;
    assign icc_z        = icc_z_q;
    assign icc_v        = icc_v_q;
    assign icc_c        = icc_c_q;
    assign icc_we       = icc_we_q;
    assign div_zero     = div_zero_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// tb/tb_ex_muldiv.sv - scoreboard testbench for ex_muldiv
module tb_ex_muldiv;
    import sparc_pkg::*;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [5:0]  op3;
    logic [31:0] valA, valB, Y_in;
    logic        ex_ready, result_valid;
    logic [31:0] result, Y_out;
    logic        icc_n, icc_z, icc_v, icc_c, icc_we, div_zero;

    typedef struct {
        logic [31:0] res;
        logic [31:0] y;
        logic        n, z, v, c;
        logic        cc;
        logic        dz;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    logic hn = 1'b0, hz = 1'b0, hv = 1'b0, hc = 1'b0;

    ex_muldiv dut (
        .clk(clk), .reset(reset), .start(start), .op3(op3),
        .valA(valA), .valB(valB), .Y_in(Y_in),
        .ex_ready(ex_ready), .result_valid(result_valid),
        .result(result), .Y_out(Y_out),
        .icc_n(icc_n), .icc_z(icc_z), .icc_v(icc_v), .icc_c(icc_c),
        .icc_we(icc_we), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [31:0] res, input logic [31:0] y,
                                input logic v, input logic cc, input logic dz, input int lat);
        exp_t e;
        e.res = res; e.y = y; e.n = res[31]; e.z = (res == 32'd0);
        e.v = v; e.c = 1'b0; e.cc = cc; e.dz = dz; e.lat = lat;
        return e;
    endfunction

    // Reference behaviour computed with wide native arithmetic.
    function automatic exp_t model(input logic [5:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [31:0] y);
        longint      sa, sb_, sp, sd, sq;
        logic [63:0] up, uq;
        exp_t        e;
        sa = longint'($signed(a));
        sb_ = longint'($signed(b));
        if (!op[2]) begin
            if (op[0]) begin
                sp = sa * sb_;
                up = sp;
            end else begin
                up = {32'd0, a} * {32'd0, b};
            end
            e = mk(up[31:0], up[63:32], 1'b0, op[4], 1'b0, 34);
        end else if (b == 32'd0) begin
            e = mk(32'hFFFF_FFFF, y, 1'b0, op[4], 1'b1, 2);
        end else if (!op[0]) begin
            if (y >= b) begin
                e = mk(32'hFFFF_FFFF, y, 1'b1, op[4], 1'b0, 2);
            end else begin
                uq = {y, a} / {32'd0, b};
                e = mk(uq[31:0], y, 1'b0, op[4], 1'b0, 34);
            end
        end else begin
            sd = $signed({y, a});
            sq = sd / sb_;
            if (sq > 64'sd2147483647) begin
                e = mk(32'h7FFF_FFFF, y, 1'b1, op[4], 1'b0, 34);
            end else if (sq < -64'sd2147483648) begin
                e = mk(32'h8000_0000, y, 1'b1, op[4], 1'b0, 34);
            end else begin
                up = sq;
                e = mk(up[31:0], y, 1'b0, op[4], 1'b0, 34);
            end
        end
        return e;
    endfunction

    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] y, input exp_t e);
        sb.push_back(e);
        op3 = op; valA = a; valB = b; Y_in = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Cycle index after acceptance at which result_valid is first seen; bounded.
    task automatic wait_valid(output int lat, output logic busy_ok);
        lat = 1;
        busy_ok = 1'b1;
        while (result_valid !== 1'b1 && lat < 60) begin
            if (ex_ready !== 1'b0) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; op3 = 6'd0; valA = 32'd0; valB = 32'd0; Y_in = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checks++; if (result !== 32'd0) begin failures++; $display("FAIL reset_result got=%h exp=0", result); end
        checks++; if (Y_out !== 32'd0) begin failures++; $display("FAIL reset_y got=%h exp=0", Y_out); end
        checks++;
        if ({icc_n, icc_z, icc_v, icc_c, icc_we, div_zero, result_valid} !== 7'd0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=0000000", {icc_n, icc_z, icc_v, icc_c, icc_we, div_zero, result_valid});
        end
        checks++; if (ex_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ex_ready); end
    endtask

    task automatic test_umul;
        exp_t e; int lat; logic busy;
        issue(OP_UMUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, mk(32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 34));
        wait_valid(lat, busy);
        e = sb.pop_front();
        checks++; if (lat != e.lat) begin failures++; $display("FAIL umul_latency got=%0d exp=%0d", lat, e.lat); end
        checks++; if (!busy) begin failures++; $display("FAIL umul_busy got=ready_high exp=ready_low"); end
        checks++; if (result !== e.res) begin failures++; $display("FAIL umul_result got=%h exp=%h", result, e.res); end
        checks++; if (Y_out !== e.y) begin failures++; $display("FAIL umul_y got=%h exp=%h", Y_out, e.y); end
        checks++; if (icc_we !== 1'b0) begin failures++; $display("FAIL umul_icc_we got=%b exp=0", icc_we); end
        checks++;
        if ({icc_n, icc_z, icc_v, icc_c} !== {hn, hz, hv, hc}) begin
            failures++; $display("FAIL umul_icc_hold got=%b exp=%b", {icc_n, icc_z, icc_v, icc_c}, {hn, hz, hv, hc});
        end
        @(posedge clk); #1;
        checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL umul_pulse got=%b exp=0", result_valid); end
        checks++; if (result !== e.res) begin failures++; $display("FAIL umul_hold got=%h exp=%h", result, e.res); end
    endtask

    task automatic test_smulcc;
        exp_t e; int lat; logic busy;
        issue(OP_SMULCC, 32'hFFFF_FFFE, 32'd3, 32'd0, mk(32'hFFFF_FFFA, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 34));
        wait_valid(lat, busy);
        e = sb.pop_front();
        checks++; if (lat != e.lat) begin failures++; $display("FAIL smulcc_latency got=%0d exp=%0d", lat, e.lat); end
        checks++; if (result !== e.res) begin failures++; $display("FAIL smulcc_result got=%h exp=%h", result, e.res); end
        checks++; if (Y_out !== e.y) begin failures++; $display("FAIL smulcc_y got=%h exp=%h", Y_out, e.y); end
        checks++;
        if ({icc_n, icc_z, icc_v, icc_c, icc_we} !== {e.n, e.z, e.v, e.c, 1'b1}) begin
            failures++; $display("FAIL smulcc_icc got=%b exp=%b", {icc_n, icc_z, icc_v, icc_c, icc_we}, {e.n, e.z, e.v, e.c, 1'b1});
        end
        {hn, hz, hv, hc} = {e.n, e.z, e.v, e.c};
    endtask

    task automatic test_back_to_back;
        exp_t e; int lat; logic busy;
        issue(OP_UDIV, 32'd100, 32'd7, 32'd0, mk(32'd14, 32'd0, 1'b0, 1'b0, 1'b0, 34));
        wait_valid(lat, busy);
        e = sb.pop_front();
        checks++; if (lat != e.lat) begin failures++; $display("FAIL udiv_latency got=%0d exp=%0d", lat, e.lat); end
        checks++; if (result !== e.res) begin failures++; $display("FAIL udiv_result got=%h exp=%h", result, e.res); end
        checks++; if (Y_out !== e.y) begin failures++; $display("FAIL udiv_y got=%h exp=%h", Y_out, e.y); end
        issue(OP_SDIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFF, mk(32'hFFFF_FFF2, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 34));
        checks++; if (ex_ready !== 1'b0) begin failures++; $display("FAIL b2b_no_idle got=%b exp=0", ex_ready); end
        wait_valid(lat, busy);
        e = sb.pop_front();
        checks++; if (lat != e.lat) begin failures++; $display("FAIL b2b_latency got=%0d exp=%0d", lat, e.lat); end
        checks++; if (result !== e.res) begin failures++; $display("FAIL b2b_result got=%h exp=%h", result, e.res); end
        checks++; if (Y_out !== e.y) begin failures++; $display("FAIL b2b_y got=%h exp=%h", Y_out, e.y); end
    endtask

    task automatic test_udiv_ovf;
        exp_t e; int lat; logic busy;
        issue(OP_UDIVCC, 32'd0, 32'd1, 32'd1, mk(32'hFFFF_FFFF, 32'd1, 1'b1, 1'b1, 1'b0, 2));
        wait_valid(lat, busy);
        e = sb.pop_front();
        checks++; if (lat != e.lat) begin failures++; $display("FAIL udivovf_latency got=%0d exp=%0d", lat, e.lat); end
        checks++; if (!busy) begin failures++; $display("FAIL udivovf_busy got=ready_high exp=ready_low"); end
        checks++; if (result !== e.res) begin failures++; $display("FAIL udivovf_result got=%h exp=%h", result, e.res); end
        checks++;
        if ({icc_n, icc_z, icc_v, icc_c, icc_we, div_zero} !== {e.n, e.z, e.v, e.c, 1'b1, 1'b0}) begin
            failures++; $display("FAIL udivovf_icc got=%b exp=%b", {icc_n, icc_z, icc_v, icc_c, icc_we, div_zero}, {e.n, e.z, e.v, e.c, 2'b10});
        end
        {hn, hz, hv, hc} = {e.n, e.z, e.v, e.c};
    endtask

    task automatic test_sdiv_sat;
        exp_t e; int lat; logic busy;
        issue(OP_SDIVCC, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mk(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 34));
        wait_valid(lat, busy);
        e = sb.pop_front();
        checks++; if (lat != e.lat) begin failures++; $display("FAIL sdivsat_latency got=%0d exp=%0d", lat, e.lat); end
        checks++; if (result !== e.res) begin failures++; $display("FAIL sdivsat_result got=%h exp=%h", result, e.res); end
        checks++;
        if ({icc_n, icc_z, icc_v, icc_c} !== {e.n, e.z, e.v, e.c}) begin
            failures++; $display("FAIL sdivsat_icc got=%b exp=%b", {icc_n, icc_z, icc_v, icc_c}, {e.n, e.z, e.v, e.c});
        end
        {hn, hz, hv, hc} = {e.n, e.z, e.v, e.c};
    endtask

    task automatic test_div_zero;
        exp_t e; int lat; logic busy;
        issue(OP_UDIV, 32'd9, 32'd0, 32'd5, mk(32'hFFFF_FFFF, 32'd5, 1'b0, 1'b0, 1'b1, 2));
        wait_valid(lat, busy);
        e = sb.pop_front();
        checks++; if (lat != e.lat) begin failures++; $display("FAIL divzero_latency got=%0d exp=%0d", lat, e.lat); end
        checks++; if (result !== e.res) begin failures++; $display("FAIL divzero_result got=%h exp=%h", result, e.res); end
        checks++; if (div_zero !== 1'b1) begin failures++; $display("FAIL divzero_flag got=%b exp=1", div_zero); end
        checks++; if (Y_out !== e.y) begin failures++; $display("FAIL divzero_y got=%h exp=%h", Y_out, e.y); end
        checks++;
        if ({icc_n, icc_z, icc_v, icc_c, icc_we} !== {hn, hz, hv, hc, 1'b0}) begin
            failures++; $display("FAIL divzero_icc_hold got=%b exp=%b", {icc_n, icc_z, icc_v, icc_c, icc_we}, {hn, hz, hv, hc, 1'b0});
        end
    endtask

    task automatic test_reset_mid;
        exp_t e; logic seen;
        issue(OP_UMUL, 32'd1234, 32'd5678, 32'd0, mk(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 34));
        e = sb.pop_back();
        for (int c = 1; c < 10; c++) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++; if (ex_ready !== 1'b1) begin failures++; $display("FAIL midreset_ready got=%b exp=1", ex_ready); end
        checks++; if (result !== 32'd0) begin failures++; $display("FAIL midreset_result got=%h exp=0", result); end
        {hn, hz, hv, hc} = 4'b0000;
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (result_valid === 1'b1) seen = 1'b1;
            @(posedge clk); #1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL midreset_valid got=%b exp=0", seen); end
    endtask

    task automatic test_reset_priority;
        logic seen;
        op3 = OP_UDIV; valA = 32'd50; valB = 32'd5; Y_in = 32'd0;
        reset = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0;
        checks++; if (ex_ready !== 1'b1) begin failures++; $display("FAIL rstprio_ready got=%b exp=1", ex_ready); end
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (result_valid === 1'b1 || ex_ready !== 1'b1) seen = 1'b1;
            @(posedge clk); #1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rstprio_activity got=%b exp=0", seen); end
    endtask

    task automatic test_invalid_op;
        logic seen;
        op3 = 6'h0C; valA = 32'd3; valB = 32'd4; Y_in = 32'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (result_valid === 1'b1 || ex_ready !== 1'b1) seen = 1'b1;
            @(posedge clk); #1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL invalid_op_activity got=%b exp=0", seen); end
    endtask

    task automatic test_random;
        logic [5:0]  ops [8];
        logic [5:0]  op;
        logic [31:0] a, b, y;
        exp_t e; int lat; logic busy;
        ops = '{OP_UMUL, OP_SMUL, OP_UDIV, OP_SDIV, OP_UMULCC, OP_SMULCC, OP_UDIVCC, OP_SDIVCC};
        for (int i = 0; i < 16; i++) begin
            op = ops[$urandom_range(0, 7)];
            a = $urandom;
            b = (i % 4 == 3) ? 32'($urandom_range(1, 20)) : $urandom;
            if (op[2] && op[0]) y = {32{a[31]}};
            else if (op[2]) y = (i % 5 == 4) ? b : 32'($urandom_range(0, 3));
            else y = $urandom;
            issue(op, a, b, y, model(op, a, b, y));
            wait_valid(lat, busy);
            e = sb.pop_front();
            checks++; if (lat != e.lat) begin failures++; $display("FAIL rand%0d_latency op=%h got=%0d exp=%0d", i, op, lat, e.lat); end
            checks++; if (result !== e.res) begin failures++; $display("FAIL rand%0d_result op=%h got=%h exp=%h", i, op, result, e.res); end
            checks++; if (Y_out !== e.y) begin failures++; $display("FAIL rand%0d_y op=%h got=%h exp=%h", i, op, Y_out, e.y); end
            if (e.cc) {hn, hz, hv, hc} = {e.n, e.z, e.v, e.c};
            checks++;
            if ({icc_n, icc_z, icc_v, icc_c, icc_we, div_zero} !== {hn, hz, hv, hc, e.cc, e.dz}) begin
                failures++;
                $display("FAIL rand%0d_flags op=%h got=%b exp=%b", i, op,
                         {icc_n, icc_z, icc_v, icc_c, icc_we, div_zero}, {hn, hz, hv, hc, e.cc, e.dz});
            end
        end
    endtask

    initial begin
        test_reset();
        test_umul();
        test_smulcc();
        test_back_to_back();
        test_udiv_ovf();
        test_sdiv_sat();
        test_div_zero();
        test_reset_mid();
        test_reset_priority();
        test_invalid_op();
        test_random();
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 SHALL have ports: clk  in  1  single clock; all state updates on posedge clk.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high; sampled on posedge clk.
REQ-003 SHALL have ports: start  in  1  request from the ID/EX register outputs: execute this op3.
REQ-004 SHALL have ports: op3  in  6  SPARC op3 code: UMUL 0x0A, SMUL 0x0B, UDIV 0x0E, SDIV 0x0F, and cc forms 0x1A/0x1B/0x1E/0x1F.
REQ-005 SHALL have ports: valA  in  32  rs1 value.
REQ-006 SHALL have ports: valB  in  32  operand2, already muxed between rs2 and sign-extended imm13.
REQ-007 SHALL have ports: Y_in  in  32  current Y register value.
REQ-008 SHALL have ports: ex_ready  out  1  stage can accept; drives the ID/EX register load enable.
REQ-009 SHALL have ports: result_valid  out  1  one-cycle pulse; result, Y_out and icc are valid.
REQ-010 SHALL have ports: result  out  32  rd value.
REQ-011 SHALL have ports: Y_out  out  32  new Y value.
REQ-012 SHALL have ports: icc_n, icc_z, icc_v, icc_c  out  1 each  condition codes.
REQ-013 SHALL have ports: icc_we  out  1  high with result_valid for cc forms only.
REQ-014 SHALL have ports: div_zero  out  1  high with result_valid when a divide had valB==0.

Function
REQ-015 SHALL implement FSM states IDLE, CALC, FIX, DONE.
REQ-016 SHALL drive ex_ready=1 in IDLE and DONE, and ex_ready=0 in CALC and FIX (decoded from state).
REQ-017 SHALL accept start only in IDLE or DONE with op3 in the set of REQ-004; any other op3 is ignored and the FSM goes to/stays IDLE.
REQ-018 SHALL, on acceptance, latch op3, valA, valB and Y_in, and enter CALC with a 5-bit iteration counter of 0.
REQ-019 SHALL run CALC for exactly 32 cycles, one radix-2 step per cycle (multiply: shift-add; divide: restoring), then go to FIX, then DONE.
REQ-020 SHALL, for a start accepted at cycle T, produce result_valid at T+34 (normal latency).
REQ-021 SHALL, for a divide where valB==0, or an unsigned divide where Y>=valB, skip CALC: FIX at T+1, DONE at T+2.
REQ-022 SHALL, for a multiply, form a 64-bit product (SMUL signed, UMUL unsigned); result=product[31:0] and Y_out=product[63:32].
REQ-023 SHALL, for a divide, use dividend {Y,valA} (64-bit) and divisor valB; the quotient goes to result and Y_out equals the latched Y.
REQ-024 SHALL, for SDIV, divide magnitudes, negate when the operand signs differ, and saturate in FIX: positive overflow gives 0x7FFFFFFF, negative overflow gives 0x80000000.
REQ-025 SHALL, on UDIV overflow, set result to 0xFFFFFFFF and V=1.
REQ-026 SHALL, on divide-by-zero, set result=0xFFFFFFFF, div_zero=1, V=0.
REQ-027 SHALL set icc as follows: N=result[31], Z=(result==0), V=divide overflow (0 for multiply), C=0.
REQ-028 SHALL set icc_we only for op3[4]=1; for other ops the icc outputs keep their previous values.
REQ-029 SHALL hold result, Y_out and icc stable after DONE until the next DONE.
REQ-030 SHALL assert result_valid only in DONE, for exactly one cycle.
REQ-031 SHALL, on a start accepted in DONE, proceed back-to-back: DONE goes directly to CALC or FIX with no IDLE bubble.

Reset
REQ-032 SHALL, with reset high at posedge clk, go to IDLE and clear result, Y_out, icc_n/z/v/c, icc_we, div_zero, result_valid and the counter to 0; ex_ready=1 the following cycle.
REQ-033 SHALL, on reset mid-operation (CALC or FIX), abandon the operation with no result_valid ever produced for it.
REQ-034 SHALL give reset priority over start in the same cycle.

Structure
REQ-035 SHALL take the op3 localparams (MUL/DIV codes) and the FSM state enum from the shared package sparc_pkg.
REQ-036 SHALL be a single module with no sub-module; the datapath is a 64-bit accumulator/remainder register plus a 32-bit operand register.

Verification
REQ-037 SHALL cover: UMUL valA=valB=0xFFFFFFFF -> result 0x00000001, Y_out 0xFFFFFFFE, result_valid at T+34, ex_ready low T+1..T+33.
REQ-038 SHALL cover: SMULcc valA=0xFFFFFFFE, valB=3 -> result 0xFFFFFFFA, Y_out 0xFFFFFFFF, N=1 Z=0 V=0 C=0, icc_we=1.
REQ-039 SHALL cover: UDIV Y=0, valA=100, valB=7 -> result 14, Y_out 0; then back-to-back SDIV start in DONE -> no IDLE cycle.
REQ-040 SHALL cover: UDIVcc Y=1, valA=0, valB=1 -> result 0xFFFFFFFF, V=1, result_valid at T+2.
REQ-041 SHALL cover: SDIVcc Y=0xFFFFFFFF, valA=0x80000000, valB=0xFFFFFFFF -> result 0x7FFFFFFF, V=1, N=0.
REQ-042 SHALL cover: UDIV valB=0 -> div_zero=1, result 0xFFFFFFFF at T+2; UMUL with reset at T+10 -> no result_valid, ex_ready=1 at T+11.
